// File: rtl/dmem_bus_bridge_if.sv
// Core/bus signal bundle for dmem_bus_bridge.
// slave  : the bridge's view. Core request and bus response are inputs; core results
//          and the bus request are outputs.
// master : the environment's view, the same signals with directions reversed.
// Core side : i_req, i_we, i_d_add, i_w_data -> o_r_data, o_stall, o_err
// Bus side  : o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata <- i_bus_ready, i_bus_rdata
interface dmem_bus_bridge_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_d_add;
  logic [WIDTH-1:0]  i_w_data;
  logic [WIDTH-1:0]  o_r_data;
  logic              o_stall;
  logic              o_err;

  logic              o_bus_valid;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [WIDTH-1:0]  o_bus_wdata;
  logic              i_bus_ready;
  logic [WIDTH-1:0]  i_bus_rdata;

  modport slave (
    input  i_req, i_we, i_d_add, i_w_data, i_bus_ready, i_bus_rdata,
    output o_r_data, o_stall, o_err, o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata
  );

  modport master (
    output i_req, i_we, i_d_add, i_w_data, i_bus_ready, i_bus_rdata,
    input  o_r_data, o_stall, o_err, o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges a stalling core data-memory port onto a valid/ready bus, one access at a time.
// A request in IDLE latches the access into the bus registers and stalls the core. BUSY
// holds the bus request until the handshake completes or TIMEOUT busy cycles pass. DONE
// releases the stall for exactly one cycle so the completing instruction can retire.
// Ports:
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : dmem_bus_bridge_if.slave, carrying the core-side and bus-side signals
module dmem_bus_bridge #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     TIMEOUT  = 16,
  parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  dmem_bus_bridge_if.slave    bus
);

  // Counter only has to reach TIMEOUT-1; the access aborts there, so it never wraps.
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                stall;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_req) begin
          // Stall in the request cycle itself so the core holds the access operands.
          stall   = 1'b1;
          state_d = StBusy;
          cnt_d   = '0;
          we_d    = bus.i_we;
          addr_d  = bus.i_d_add;
          wdata_d = bus.i_w_data;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (bus.i_bus_ready) begin
          // A handshake on the final count still wins over the abort.
          if (!we_q) rdata_d = bus.i_bus_rdata;
          state_d = StDone;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        // i_req is still the retiring instruction's request here, so it is ignored.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs come only from registers, so no bus input reaches a bus output.
  assign bus.o_bus_valid = (state_q == StBusy);
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign bus.o_r_data    = rdata_q;
  assign bus.o_err       = err_q;
  assign bus.o_stall     = stall;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge. The driver issues accesses and pushes the expected
// outcome of each onto a queue. The monitor checks the DUT on every falling clock edge and
// pops one expectation each time a bus transfer ends.
module tb_dmem_bus_bridge;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;

  dmem_bus_bridge_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

  dmem_bus_bridge #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus_if)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] r_data;
    logic        err;
    int          valid_cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_r  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference outcome of one access. The bus answers in busy cycle wait_n+1, so the access
  // finishes normally only when that falls within the first TIMEOUT busy cycles.
  function automatic exp_t predict(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int wait_n,
                                   input logic [31:0] rdata);
    exp_t e;
    bit   ok;
    ok             = (wait_n < int'(TIMEOUT));
    e.we           = we;
    e.addr         = addr;
    e.wdata        = wdata;
    e.err          = !ok;
    e.valid_cycles = ok ? wait_n + 1 : int'(TIMEOUT);
    if (!ok)     e.r_data = ERR_DATA;
    else if (we) e.r_data = model_r;
    else         e.r_data = rdata;
    return e;
  endfunction

  // Entered and left at 1 time unit after a rising edge. i_req stays high through DONE.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int wait_n, input logic [31:0] rdata);
    exp_t e;
    e = predict(we, addr, wdata, wait_n, rdata);
    model_r = e.r_data;
    exp_q.push_back(e);
    bus_if.i_req       = 1'b1;
    bus_if.i_we        = we;
    bus_if.i_d_add     = addr;
    bus_if.i_w_data    = wdata;
    bus_if.i_bus_ready = 1'b0;
    bus_if.i_bus_rdata = $urandom;
    for (int n = 1; n <= int'(TIMEOUT); n++) begin
      @(posedge i_clk); #1;
      // Scramble the core operands; the bus side must keep the latched values.
      bus_if.i_we        = 1'($urandom);
      bus_if.i_d_add     = $urandom;
      bus_if.i_w_data    = $urandom;
      bus_if.i_bus_ready = (n == wait_n + 1);
      bus_if.i_bus_rdata = (n == wait_n + 1) ? rdata : $urandom;
      if (n == wait_n + 1) break;
    end
    @(posedge i_clk); #1;
    bus_if.i_bus_ready = 1'b0;
    bus_if.i_bus_rdata = $urandom;
    @(posedge i_clk); #1;
    bus_if.i_req = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.i_req = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
      bus_if.i_bus_ready = 1'($urandom);
      bus_if.i_bus_rdata = $urandom;
    end
    bus_if.i_bus_ready = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin
    bit          prev_valid = 1'b0;
    int          vcnt       = 0;
    logic [31:0] mon_r      = '0;
    exp_t        e;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        check("rst_bus_valid", bus_if.o_bus_valid, 0);
        check("rst_stall", bus_if.o_stall, bus_if.i_req);
        check("rst_r_data", bus_if.o_r_data, 0);
        check("rst_err", bus_if.o_err, 0);
        exp_q.delete();
        prev_valid = 1'b0;
        vcnt       = 0;
        mon_r      = '0;
      end else begin
        if (prev_valid && !bus_if.o_bus_valid) begin
          check("done_exp_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("done_r_data", bus_if.o_r_data, e.r_data);
            check("done_err", bus_if.o_err, e.err);
            check("done_valid_cycles", vcnt, e.valid_cycles);
            mon_r = e.r_data;
          end
          check("done_stall", bus_if.o_stall, 0);
          vcnt = 0;
        end else begin
          check("r_data_hold", bus_if.o_r_data, mon_r);
          check("err_quiet", bus_if.o_err, 0);
          if (bus_if.o_bus_valid) begin
            vcnt++;
            check("busy_stall", bus_if.o_stall, 1);
            check("busy_exp_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              check("bus_we", bus_if.o_bus_we, exp_q[0].we);
              check("bus_addr", bus_if.o_bus_addr, exp_q[0].addr);
              check("bus_wdata", bus_if.o_bus_wdata, exp_q[0].wdata);
            end
          end else begin
            check("idle_stall", bus_if.o_stall, bus_if.i_req);
          end
        end
        prev_valid = bus_if.o_bus_valid;
      end
    end
  end

  // Stimulus.
  initial begin
    int r;
    int w;
    bus_if.i_req       = 1'b0;
    bus_if.i_we        = 1'b0;
    bus_if.i_d_add     = '0;
    bus_if.i_w_data    = '0;
    bus_if.i_bus_ready = 1'b0;
    bus_if.i_bus_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    idle(2);

    // Zero-wait load, 3-wait store, timeout, ready on the last count.
    issue(1'b0, 32'h100, 32'h0, 0, 32'h1234_5678);
    idle(1);
    issue(1'b1, 32'h200, 32'hA5A5_A5A5, 3, 32'hFFFF_0000);
    idle(1);
    issue(1'b0, 32'h300, 32'h0, 1000, 32'h0);
    idle(1);
    issue(1'b0, 32'h304, 32'h0, int'(TIMEOUT) - 1, 32'h55);
    // Back-to-back loads with i_req held high.
    issue(1'b0, 32'h400, 32'h0, 1, 32'h1111_2222);
    issue(1'b0, 32'h404, 32'h0, 2, 32'h3333_4444);
    idle(1);
    // Store that times out still returns the error word.
    issue(1'b1, 32'h500, 32'hCAFE_F00D, int'(TIMEOUT), 32'h0);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      w = int'($urandom_range(0, 3));
      else if (r < 8) w = int'($urandom_range(4, TIMEOUT - 1));
      else            w = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
      issue(1'($urandom), $urandom, $urandom, w, $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    // Reset asserted in the second busy cycle of a load.
    bus_if.i_req   = 1'b1;
    bus_if.i_we    = 1'b0;
    bus_if.i_d_add = 32'h600;
    exp_q.push_back(predict(1'b0, 32'h600, bus_if.i_w_data, 1000, 32'h0));
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rstn       = 1'b0;
    bus_if.i_req = 1'b0;
    model_r      = '0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    issue(1'b0, 32'h100, 32'h0, 0, 32'h1234_5678);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: data width of the core port and the bus port.
REQ-002 SHALL have parameter ADDR_W, default 32: data address width, equal to the core's D_ADD_SIZE.
REQ-003 SHALL have parameter TIMEOUT, default 16, legal range 2..255: number of BUSY cycles allowed before the access aborts.
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on an aborted access.

Interface
Clock and reset
REQ-005 i_clk  in  1  single clock; every register updates on the rising edge.
REQ-006 i_rstn  in  1  reset; asynchronous, active-low.

Core side
REQ-007 i_req  in  1  core data-memory access request (load or store).
REQ-008 i_we  in  1  1 = store, 0 = load.
REQ-009 i_d_add  in  ADDR_W  access address.
REQ-010 i_w_data  in  WIDTH  store data.
REQ-011 o_r_data  out  WIDTH  registered load data.
REQ-012 o_stall  out  1  freezes the core pipeline while high.
REQ-013 o_err  out  1  one-cycle pulse marking an aborted access.

Bus side
REQ-014 o_bus_valid  out  1  transfer request to the bus.
REQ-015 o_bus_we  out  1  transfer direction, 1 = write.
REQ-016 o_bus_addr  out  ADDR_W  transfer address.
REQ-017 o_bus_wdata  out  WIDTH  write data.
REQ-018 i_bus_ready  in  1  transfer completes in any cycle where o_bus_valid and i_bus_ready are both high.
REQ-019 i_bus_rdata  in  WIDTH  read data, valid only in a cycle where i_bus_ready is high.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 In IDLE with i_req=1:
- latch i_we, i_d_add and i_w_data into the bus output registers;
- clear the timeout counter;
- go to BUSY;
- drive o_stall=1 combinationally in that same cycle.
REQ-022 In IDLE with i_req=0: stay in IDLE; o_stall=0; o_bus_valid=0.
REQ-023 In BUSY:
- o_bus_valid=1 and o_stall=1;
- o_bus_we, o_bus_addr and o_bus_wdata SHALL stay constant until the handshake completes or the access aborts.
REQ-024 In BUSY with i_bus_ready=1:
- on a load, capture i_bus_rdata into o_r_data;
- on a store, leave o_r_data unchanged;
- go to DONE.
REQ-025 In BUSY with i_bus_ready=0: increment the counter.
REQ-026 If the counter equals TIMEOUT-1 and i_bus_ready=0 in the same cycle:
- load ERR_DATA into o_r_data (loads and stores alike);
- pulse o_err for the next cycle only;
- go to DONE.
REQ-027 If the counter equals TIMEOUT-1 and i_bus_ready=1 in the same cycle: the handshake wins; no error.
REQ-028 In DONE:
- o_stall=0 and o_bus_valid=0, so the core advances this cycle;
- i_req is ignored, because it is the completing instruction's own request;
- go to IDLE unconditionally.
REQ-029 Latency: with i_req rising in cycle 0 and i_bus_ready first high in cycle k≥1:
- o_stall is high in cycles 0..k;
- o_r_data is valid from cycle k+1 (DONE).
- Minimum is two stall cycles.
REQ-030 o_r_data SHALL hold its value until the next completed or aborted access.
REQ-031 The counter SHALL be wide enough for TIMEOUT-1 and SHALL never wrap.
REQ-032 No combinational path SHALL exist from any bus input to any bus output.

Reset
REQ-033 On i_rstn low, regardless of state or an in-flight handshake, immediately set:
- state = IDLE, counter = 0;
- o_bus_valid = 0, o_bus_we = 0, o_bus_addr = 0, o_bus_wdata = 0;
- o_r_data = 0, o_err = 0.
- o_stall follows its IDLE rule (REQ-021/REQ-022).
REQ-034 Reset release SHALL take effect on the first rising edge of i_clk after i_rstn goes high.

Verification
REQ-035 Load, zero wait states: load to 0x100 in cycle 0, i_bus_ready=1 with rdata 0x1234_5678 in cycle 1 -> o_stall high in cycles 0–1, o_r_data=0x1234_5678 and o_stall=0 in cycle 2.
REQ-036 Store, 3 wait states: store 0xA5A5_A5A5 to 0x200, ready first high in cycle 4 -> o_bus_valid high in cycles 1–4 with address and data stable, o_r_data unchanged, o_stall low in cycle 5.
REQ-037 Timeout: TIMEOUT=16, load with ready never asserted -> o_bus_valid high for 16 cycles, then o_r_data=0xDEAD_BEEF and o_err=1 for exactly one cycle, then FSM in IDLE.
REQ-038 Ready on the last count: ready arrives on the 16th BUSY cycle with rdata 0x55 -> o_r_data=0x55 and o_err stays 0.
REQ-039 Back-to-back: i_req held high across two loads -> a DONE cycle separates the two BUSY phases, and each load gets its own bus transfer.
REQ-040 Reset mid-access: i_rstn low in the 2nd BUSY cycle -> o_bus_valid=0, o_stall=0 and o_r_data=0 in the same cycle; after release, the first request behaves as REQ-035.
